// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: counter encodings, BTB entry layout and
// the table-index hash also used by the pipeline.
package bp_pkg;

    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;

    // Fields are sized for the widest legal configuration; narrower
    // instances zero-extend on write and truncate on read.
    localparam int BP_IDX_MAX  = 16;
    localparam int BP_TAG_MAX  = 16;
    localparam int BP_XLEN_MAX = 64;

    typedef struct packed {
        logic                   valid;
        logic [BP_TAG_MAX-1:0]  tag;
        logic [BP_XLEN_MAX-1:0] target;
    } btb_entry_t;

    // pc carries the low index bits; ghr arrives zero-extended, which makes
    // the XOR fold the history into the low bits only.
    function automatic logic [BP_IDX_MAX-1:0] bp_index(
        input logic [BP_IDX_MAX-1:0] pc,
        input logic [BP_IDX_MAX-1:0] ghr
    );
        return pc ^ ghr;
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating counter next-state logic: steps toward ST on taken,
// toward SNT on not-taken, and sticks at either end.
module sat_counter2
    import bp_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != ST) ctr_next = ctr + 2'd1;
        end else begin
            if (ctr != SNT) ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor_table.sv
// Bimodal/gshare direction table plus tagged BTB. Predicts combinationally for
// the branch in ID; trained by the branch resolved in EX with GHR repair.
module branch_predictor_table
    import bp_pkg::*;
#(
    parameter int         ENTRIES   = 64,
    parameter int         HIST_BITS = 6,
    parameter int         TAG_BITS  = 8,
    parameter int         XLEN      = 32,
    parameter logic [1:0] CTR_INIT  = WNT,
    localparam int        IDXW      = $clog2(ENTRIES),
    localparam int        GW        = (HIST_BITS > 0) ? HIST_BITS : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pred_valid_ID,
    input  logic            stall,
    input  logic [XLEN-1:0] pred_pc_ID,
    output logic            pred_taken_ID,
    output logic            pred_hit_ID,
    output logic [XLEN-1:0] pred_target_ID,
    output logic [IDXW-1:0] pred_idx_ID,
    output logic [GW-1:0]   pred_ghr_ID,
    input  logic            update_EX,
    input  logic [XLEN-1:0] update_pc_EX,
    input  logic [IDXW-1:0] update_idx_EX,
    input  logic [GW-1:0]   update_ghr_EX,
    input  logic            update_taken_EX,
    input  logic [XLEN-1:0] update_target_EX,
    input  logic            mispredict_EX,
    input  logic            btb_clear,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
);

    logic [1:0]     ctr [ENTRIES];
    btb_entry_t     btb [ENTRIES];
    logic [GW-1:0]  ghr_q;
    logic [GW-1:0]  ghr_next;
    logic [31:0]    stat_br_q;
    logic [31:0]    stat_mis_q;

    logic [IDXW-1:0]     idx;
    logic [IDXW-1:0]     btb_rd_idx;
    logic [IDXW-1:0]     btb_wr_idx;
    logic [TAG_BITS-1:0] rd_tag;
    logic [TAG_BITS-1:0] wr_tag;
    btb_entry_t          rd_entry;
    logic [1:0]          upd_ctr_cur;
    logic [1:0]          upd_ctr_next;

    // With no history ghr_q is held at zero, so this degenerates to pc bits.
    assign idx        = IDXW'(bp_index(BP_IDX_MAX'(pred_pc_ID[IDXW-1:0]), BP_IDX_MAX'(ghr_q)));
    assign btb_rd_idx = pred_pc_ID[IDXW-1:0];
    assign btb_wr_idx = update_pc_EX[IDXW-1:0];
    assign rd_tag     = pred_pc_ID[IDXW+TAG_BITS-1:IDXW];
    assign wr_tag     = update_pc_EX[IDXW+TAG_BITS-1:IDXW];
    assign rd_entry   = btb[btb_rd_idx];

    assign pred_hit_ID    = rd_entry.valid && (rd_entry.tag == BP_TAG_MAX'(rd_tag));
    assign pred_taken_ID  = ctr[idx][1] & pred_hit_ID;
    assign pred_target_ID = pred_hit_ID ? XLEN'(rd_entry.target) : '0;
    assign pred_idx_ID    = idx;
    assign pred_ghr_ID    = ghr_q;

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mis_q;

    assign upd_ctr_cur = ctr[update_idx_EX];

    sat_counter2 u_sat (
        .ctr      (upd_ctr_cur),
        .taken    (update_taken_EX),
        .ctr_next (upd_ctr_next)
    );

    // Repair from the EX snapshot outranks the speculative shift from ID.
    generate
        if (HIST_BITS == 0) begin : g_no_hist
            logic unused_hist;
            assign unused_hist = ^{update_ghr_EX, pred_valid_ID, stall};
            assign ghr_next    = '0;
        end else if (HIST_BITS == 1) begin : g_hist1
            logic unused_hist;
            assign unused_hist = ^update_ghr_EX;
            always_comb begin
                ghr_next = ghr_q;
                if (update_EX && mispredict_EX)  ghr_next = update_taken_EX;
                else if (pred_valid_ID && !stall) ghr_next = pred_taken_ID;
            end
        end else begin : g_hist
            logic unused_hist;
            assign unused_hist = update_ghr_EX[HIST_BITS-1];
            always_comb begin
                ghr_next = ghr_q;
                if (update_EX && mispredict_EX)
                    ghr_next = {update_ghr_EX[HIST_BITS-2:0], update_taken_EX};
                else if (pred_valid_ID && !stall)
                    ghr_next = {ghr_q[HIST_BITS-2:0], pred_taken_ID};
            end
        end

        if (IDXW + TAG_BITS < XLEN) begin : g_pc_hi
            logic unused_pc_hi;
            assign unused_pc_hi = ^{pred_pc_ID[XLEN-1:IDXW+TAG_BITS],
                                    update_pc_EX[XLEN-1:IDXW+TAG_BITS]};
        end
    endgenerate

    // The taken-update write comes after the clear so a coinciding
    // allocation survives the flash invalidate.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr[i]       <= CTR_INIT;
                btb[i].valid <= 1'b0;
            end
            ghr_q      <= '0;
            stat_br_q  <= '0;
            stat_mis_q <= '0;
        end else begin
            if (btb_clear) begin
                for (int i = 0; i < ENTRIES; i++) btb[i].valid <= 1'b0;
            end
            if (update_EX) begin
                ctr[update_idx_EX] <= upd_ctr_next;
                if (update_taken_EX) begin
                    btb[btb_wr_idx].valid  <= 1'b1;
                    btb[btb_wr_idx].tag    <= BP_TAG_MAX'(wr_tag);
                    btb[btb_wr_idx].target <= BP_XLEN_MAX'(update_target_EX);
                end
            end
            ghr_q <= ghr_next;
            if (update_EX && (stat_br_q != 32'hFFFF_FFFF))
                stat_br_q <= stat_br_q + 32'd1;
            if (update_EX && mispredict_EX && (stat_mis_q != 32'hFFFF_FFFF))
                stat_mis_q <= stat_mis_q + 32'd1;
        end
    end

endmodule

// File: doc/branch_predictor_table.md
# branch_predictor_table

Parametrised successor to the single global 2-bit branch predictor in the five-stage pipeline. Holds a per-index table of 2-bit saturating counters plus a tagged branch target buffer (BTB). The table is indexed bimodally or gshare-style from a speculative global history register (GHR). Sits beside the ID stage: it predicts combinationally for the branch in ID and is trained by the branch resolved in EX, with GHR repair on mispredict.

## Interface
Parameters:
- `ENTRIES`, 64: counter/BTB entries; power of two, 4..1024; `IDXW = $clog2(ENTRIES)`.
- `HIST_BITS`, 6: GHR length, 0..`IDXW`; 0 selects pure bimodal indexing.
- `TAG_BITS`, 8: BTB tag width, 1..16.
- `XLEN`, 32: PC/target width.
- `CTR_INIT`, 2'b01: counter reset value (weakly not-taken).

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `pred_valid_ID` in 1: instruction in ID is a conditional branch.
- `stall` in 1: ID held this cycle; suppresses the speculative GHR shift.
- `pred_pc_ID` in XLEN: word-addressed PC of the ID instruction.
- `pred_taken_ID` out 1: predicted direction, equal to `ctr[idx][1] & pred_hit_ID`.
- `pred_hit_ID` out 1: BTB valid and tag match.
- `pred_target_ID` out XLEN: BTB target; 0 when not hit.
- `pred_idx_ID` out IDXW: index used, piped to EX.
- `pred_ghr_ID` out max(HIST_BITS,1): GHR snapshot before this prediction, piped to EX.
- `update_EX` in 1: resolved conditional branch in EX.
- `update_pc_EX` in XLEN: its PC.
- `update_idx_EX` in IDXW: its piped index.
- `update_ghr_EX` in max(HIST_BITS,1): its piped GHR snapshot.
- `update_taken_EX` in 1: actual outcome.
- `update_target_EX` in XLEN: computed target.
- `mispredict_EX` in 1: direction or target wrong; qualified by `update_EX`.
- `btb_clear` in 1: invalidate all BTB entries next edge.
- `stat_branches` out 32: count of `update_EX` pulses, saturating at 0xFFFFFFFF.
- `stat_mispredicts` out 32: count of `update_EX & mispredict_EX` pulses, saturating.

## Operation
- Index: `idx = pred_pc_ID[IDXW-1:0] ^ {{(IDXW-HIST_BITS){1'b0}}, ghr}`. With `HIST_BITS=0`, `idx = pc[IDXW-1:0]`.
- Tag: `pc[IDXW+TAG_BITS-1:IDXW]`. The BTB is indexed by `pc[IDXW-1:0]` (never hashed).
- Speculative GHR: when `pred_valid_ID & ~stall`, the next value is `{ghr[HIST_BITS-2:0], pred_taken_ID}`.
- Mispredict repair: when `update_EX & mispredict_EX`, the next value is `{update_ghr_EX[HIST_BITS-2:0], update_taken_EX}`. Repair has priority over the speculative shift in the same cycle.
- Training on `update_EX`:
  - `ctr[update_idx_EX]` increments if taken, decrements if not, saturating at 3 and 0.
  - If taken, BTB entry `update_pc_EX[IDXW-1:0]` is written with valid=1, tag, and `update_target_EX`.
  - Not-taken branches never allocate and never invalidate BTB entries.
- `btb_clear` clears valid bits only; counters, GHR and statistics are unaffected. If `btb_clear` coincides with a taken update, the update's entry ends valid.

## Timing
- Prediction outputs are combinational from registered state and ID inputs; no added latency.
- Updates take effect at the next rising edge. A same-cycle read of the entry being written returns the old value (no bypass).
- Reset (one cycle) sets:
  - all counters to `CTR_INIT`;
  - all BTB valid bits to 0;
  - GHR to 0;
  - statistics to 0.
- Consequently, after reset `pred_taken_ID=0`, `pred_hit_ID=0`, `pred_target_ID=0`.
- `rst` has priority over every other input. Reset asserted mid-update discards the update.
- Statistics counters stop at all-ones; they do not wrap.

## Structure
- Shared package `bp_pkg`:
  - counter encoding constants `SNT=0`, `WNT=1`, `WT=2`, `ST=3`;
  - `btb_entry_t` struct (valid, tag, target);
  - function `bp_index(pc, ghr)` shared with the pipeline.
- One sub-module: `sat_counter2` (2-bit saturating next-state logic, combinational), instantiated once for the update path.

## Test plan
- Reset, then `pred_pc_ID=0x10`, `pred_valid_ID=1`, `HIST_BITS=0` -> `pred_taken_ID=0`, `pred_hit_ID=0`, `pred_target_ID=0`.
- Three taken updates at pc 0x10, target 0x40 (`HIST_BITS=0`) -> counter 1→2→3→3; next predict at 0x10 gives `taken=1`, `hit=1`, `target=0x40`.
- Prediction at pc `0x10 + ENTRIES` after training 0x10 -> tag mismatch gives `hit=0`, `taken=0`; the counter is shared but gated.
- gshare (`HIST_BITS=6`): three predictions not-taken with no stall -> GHR=0b000000. Mispredict with snapshot 0b101010 and taken=1 -> GHR=0b010101 next cycle, overriding a simultaneous speculative shift.
- `stall=1` with `pred_valid_ID=1` -> GHR unchanged. `btb_clear` for one cycle -> all hits 0; counters retain their values.
- Force `stat_mispredicts` to 0xFFFFFFFE, then apply two mispredict updates -> value holds at 0xFFFFFFFF; `rst` returns it to 0.
